// File: rtl/ifu_pkg.sv
// Shared types and constants for the prefetching instruction fetch unit.
package ifu_pkg;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RSP
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/ifu_fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush wins over push and pop.
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int  FQ_DEPTH = 4,
    parameter type entry_t  = fq_entry_t
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      push,
    input  entry_t                    push_data,
    input  logic                      pop,
    output entry_t                    head,
    output logic                      empty,
    output logic [$clog2(FQ_DEPTH):0] count
);

    localparam int AW = $clog2(FQ_DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem [FQ_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (count != CW'(FQ_DEPTH));
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with prefetch queue and flush-on-redirect.
// Optional saturating perf counters under IFU_PREFETCH_PERF_EN.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               ILEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               FQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [ILEN-1:0] if_instr,
    input  logic            if_ready
`ifdef IFU_PREFETCH_PERF_EN
   ,output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            drop_q;
    logic [CW-1:0]   fq_count;
    logic [CW-1:0]   occ_next;
    logic            fq_empty;
    entry_t          fq_head;
    entry_t          fq_in;
    logic            gnt_ok, rsp, push, pop, can_issue;

    assign gnt_ok = (state_q == WAIT_GNT) && imem_gnt && !redirect_valid;
    assign rsp    = (state_q == WAIT_RSP) && imem_rvalid;
    assign push   = rsp && !drop_q && !redirect_valid;
    assign pop    = if_valid && if_ready && !redirect_valid;

    // Occupancy after this edge; the slot for the next request must already be free.
    assign occ_next  = fq_count + CW'(push) - CW'(pop);
    assign can_issue = !stall && !redirect_valid && (occ_next < CW'(FQ_DEPTH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (can_issue) state_d = WAIT_GNT;
            WAIT_GNT: begin
                if (redirect_valid) state_d = IDLE;
                else if (imem_gnt)  state_d = WAIT_RSP;
            end
            WAIT_RSP: if (imem_rvalid) state_d = can_issue ? WAIT_GNT : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (redirect_valid)
                fetch_pc_q <= redirect_pc & ~XLEN'(INSTR_BYTES - 1);
            else if (gnt_ok)
                fetch_pc_q <= fetch_pc_q + XLEN'(INSTR_BYTES);
            if (gnt_ok) req_pc_q <= fetch_pc_q;
            // Redirect before the response lands: swallow whatever comes back.
            if (redirect_valid && (state_q == WAIT_RSP) && !imem_rvalid)
                drop_q <= 1'b1;
            else if (rsp)
                drop_q <= 1'b0;
        end
    end

    assign imem_req  = (state_q == WAIT_GNT) && !redirect_valid;
    assign imem_addr = fetch_pc_q;

    assign fq_in.pc    = req_pc_q;
    assign fq_in.instr = imem_rdata;

    ifu_fetch_queue #(
        .FQ_DEPTH (FQ_DEPTH),
        .entry_t  (entry_t)
    ) u_fq (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (fq_in),
        .pop       (pop),
        .head      (fq_head),
        .empty     (fq_empty),
        .count     (fq_count)
    );

    assign if_valid = !fq_empty;
    assign if_pc    = fq_head.pc;
    assign if_instr = fq_empty ? ILEN'(NOP_INSTR) : fq_head.instr;

`ifdef IFU_PREFETCH_PERF_EN
    logic [32:0] flushed_sum;
    assign flushed_sum = {1'b0, perf_flushed} + 33'(fq_count) + 33'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
            if (redirect_valid) perf_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: randomized memory/decode/redirect traffic plus directed cases.
module tb_ifu_prefetch;

    localparam int FQ_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, redirect_valid = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0, if_ready = 1'b0;
    logic [31:0] redirect_pc = '0, imem_rdata = '0;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_pc, if_instr;
`ifdef IFU_PREFETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    always #5 clk = ~clk;

    ifu_prefetch #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0), .FQ_DEPTH(FQ_DEPTH)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready)
`ifdef IFU_PREFETCH_PERF_EN
       ,.perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0, errors = 0;
    bit          in_reset = 1'b1;
    logic [31:0] pc_m = 32'h0;
    bit          outst = 1'b0, cancel = 1'b0;
    logic [31:0] rsp_pc = '0;
    int          rsp_wait = 0, lat_mode = 0;
    int          pushes = 0, pop_cnt = 0, flushed_m = 0;
    logic [31:0] last_pop_pc = '0, last_gnt_addr = '0;
    bit          got_gnt = 1'b0, got_rsp = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, observe handshakes, then advance the reference model after the edge.
    task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy, input bit gnt);
        bit          g, rv;
        logic [31:0] a;
        @(negedge clk);
        stall = st; redirect_valid = rd; redirect_pc = rpc; if_ready = rdy; imem_gnt = gnt;
        imem_rvalid = outst ? (rsp_wait == 0) : ($urandom_range(0, 7) == 0);
        imem_rdata  = outst ? mem_word(rsp_pc) : $urandom;
        #1;
        g  = imem_req && imem_gnt;
        rv = outst && imem_rvalid;
        a  = imem_addr;
        if (rd) chk("req_during_redirect", imem_req, 0);
        if (imem_req) chk("req_has_room", sbq.size() < FQ_DEPTH, 1);
        if (g) chk("imem_addr", a, pc_m);
        @(posedge clk);
        #1;
        got_gnt = g;
        got_rsp = rv;
        if (rd) begin
            flushed_m += 1 + sbq.size();
            sbq.delete();
            pc_m = {rpc[31:2], 2'b00};
            if (outst) cancel = 1'b1;
        end
        if (rv) begin
            if (!cancel) begin
                sbq.push_back('{rsp_pc, mem_word(rsp_pc)});
                pushes++;
            end
            outst = 1'b0;
        end else if (outst && rsp_wait > 0) begin
            rsp_wait--;
        end
        if (g) begin
            outst = 1'b1; cancel = 1'b0; rsp_pc = pc_m; pc_m = pc_m + 32'd4;
            last_gnt_addr = a;
            rsp_wait = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        end
    endtask

    task automatic wait_gnt(input string name, input logic [31:0] exp);
        bit ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 1, 1);
            if (got_gnt) begin ok = 1'b1; break; end
        end
        if (ok) chk(name, last_gnt_addr, exp);
        else    chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic fetch_one(input bit rdy);
        step(0, 0, 0, rdy, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, rdy, 1);
            if (got_rsp) break;
        end
    endtask

    // Monitor: compares the queue head against the scoreboard whenever decode takes it.
    initial forever begin
        @(negedge clk);
        #2;
        if (!in_reset) begin
            chk("if_valid", if_valid, sbq.size() != 0);
            if (if_valid && if_ready && !redirect_valid && sbq.size() != 0) begin
                chk("if_pc", if_pc, sbq[0].pc);
                chk("if_instr", if_instr, sbq[0].instr);
                last_pop_pc = if_pc;
                pop_cnt++;
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int          p0;
        logic [31:0] exp_pc;
`ifdef IFU_PREFETCH_PERF_EN
        logic [31:0] f0, l0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_imem_req", imem_req, 0);
`ifdef IFU_PREFETCH_PERF_EN
        chk("rst_perf_fetched", perf_fetched, 0);
        chk("rst_perf_flushed", perf_flushed, 0);
`endif
        reset = 1'b0;
        in_reset = 1'b0;

        // Back-to-back fetch with 1-cycle memory latency.
        step(0, 0, 0, 1, 1);
        chk("first_req_granted", got_gnt, 1);
        chk("first_addr", last_gnt_addr, 32'h0);
        chk("valid_not_before_n2", if_valid, 0);
        step(0, 0, 0, 1, 1);
        chk("valid_at_n2", if_valid, 1);
        chk("first_if_pc", if_pc, 32'h0);
        repeat (10) step(0, 0, 0, 1, 1);

        // Decode blocked: queue fills to exactly FQ_DEPTH and fetching stops.
        step(0, 1, 32'h0, 0, 1);
        repeat (20) step(0, 0, 0, 0, 1);
        chk("fill_size", sbq.size(), FQ_DEPTH);
        chk("fill_head_pc", sbq[0].pc, 32'h0);
        chk("fill_tail_pc", sbq[FQ_DEPTH-1].pc, 32'hC);
        chk("fill_no_req", imem_req, 0);
        chk("fill_valid", if_valid, 1);
        wait_gnt("resume_addr", 32'h10);

        // Redirect while waiting on the response for 0x8.
        lat_mode = 2;
        step(0, 1, 32'h0, 1, 1);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 1, 1);
            if (got_gnt && last_gnt_addr == 32'h8) break;
        end
        chk("gnt_0x8", last_gnt_addr, 32'h8);
        step(0, 1, 32'h200, 1, 1);
        p0 = pop_cnt;
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 0, 1, 1);
            if (pop_cnt > p0) break;
        end
        chk("post_redirect_pc", last_pop_pc, 32'h200);
        lat_mode = 0;

        // Unaligned redirect with a full queue.
        step(0, 1, 32'h0, 0, 1);
        repeat (20) step(0, 0, 0, 0, 1);
        chk("full_before_redirect", sbq.size(), FQ_DEPTH);
        step(0, 1, 32'h103, 0, 1);
        chk("flush_if_valid", if_valid, 0);
        wait_gnt("unaligned_target", 32'h100);

        // Stall with two entries queued.
        step(0, 1, 32'h40, 0, 1);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 1);
            if (sbq.size() == 2) break;
        end
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 1);
            if (i >= 2) chk("stall_no_req", imem_req, 0);
        end
        repeat (6) step(1, 0, 0, 1, 1);
        chk("stall_drained", if_valid, 0);
        chk("stall_drained_req", imem_req, 0);
        exp_pc = pc_m;
        wait_gnt("stall_resume", exp_pc);

        // Address wrap.
        step(0, 1, 32'hFFFF_FFFC, 1, 1);
        wait_gnt("wrap_last", 32'hFFFF_FFFC);
        wait_gnt("wrap_zero", 32'h0);

`ifdef IFU_PREFETCH_PERF_EN
        step(1, 1, 32'h300, 1, 0);
        repeat (6) step(1, 0, 0, 1, 1);
        f0 = perf_fetched;
        l0 = perf_flushed;
        repeat (3) fetch_one(1);
        repeat (3) step(1, 0, 0, 1, 0);
        repeat (3) fetch_one(0);
        step(1, 1, 32'h400, 0, 0);
        chk("perf_fetched_delta", perf_fetched - f0, 6);
        chk("perf_flushed_delta", perf_flushed - l0, 4);
`endif

        // Randomized traffic.
        lat_mode = -1;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom & 32'h0000_FFFF,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
        end
        lat_mode = 0;
        repeat (12) step(0, 0, 0, 1, 1);

`ifdef IFU_PREFETCH_PERF_EN
        chk("perf_fetched_total", perf_fetched, pushes);
        chk("perf_flushed_total", perf_flushed, flushed_m);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
